// File: rtl/vram_arbiter_if.sv
// Requester, controller and status signals shared between the VRAM arbiter and its users.
interface vram_arbiter_if;
    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 32;

    // SDRAM initialisation done
    logic                mem_enabled;

    // Renderer: 32-bit reads only
    logic                rend_req;
    logic [ADDR_W-1:0]   rend_addr;
    logic                rend_ack;
    logic                rend_rd_valid;

    // Command engine: 8/16/32-bit writes, reads
    logic                cmd_req;
    logic                cmd_wr;
    logic [1:0]          cmd_size;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_din;
    logic                cmd_ack;
    logic                cmd_rd_valid;

    // CPU port: byte accesses
    logic                cpu_req;
    logic                cpu_wr;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [7:0]          cpu_din;
    logic                cpu_ack;
    logic                cpu_rd_valid;

    // Memory controller command side
    logic                mc_read;
    logic                mc_write;
    logic                mc_refresh;
    logic [ADDR_W-1:0]   mc_addr;
    logic [1:0]          mc_word_wr_size;
    logic [DATA_W-1:0]   mc_din;

    // Sticky refresh backlog flag
    logic                refresh_overrun;

    // Arbiter side
    modport slave (
        input  mem_enabled,
        input  rend_req, rend_addr,
        output rend_ack, rend_rd_valid,
        input  cmd_req, cmd_wr, cmd_size, cmd_addr, cmd_din,
        output cmd_ack, cmd_rd_valid,
        input  cpu_req, cpu_wr, cpu_addr, cpu_din,
        output cpu_ack, cpu_rd_valid,
        output mc_read, mc_write, mc_refresh, mc_addr, mc_word_wr_size, mc_din,
        output refresh_overrun
    );

    // Requester / controller side
    modport master (
        output mem_enabled,
        output rend_req, rend_addr,
        input  rend_ack, rend_rd_valid,
        output cmd_req, cmd_wr, cmd_size, cmd_addr, cmd_din,
        input  cmd_ack, cmd_rd_valid,
        output cpu_req, cpu_wr, cpu_addr, cpu_din,
        input  cpu_ack, cpu_rd_valid,
        input  mc_read, mc_write, mc_refresh, mc_addr, mc_word_wr_size, mc_din,
        input  refresh_overrun
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: sole master of the SDRAM controller. Shares it between renderer,
// command engine and CPU port, injects periodic auto-refresh, and runs one
// operation per fixed-length slot with address/data held for the whole slot.
module vram_arbiter #(
    parameter int unsigned FREQ             = 54_000_000,
    parameter int unsigned SLOT_CYCLES      = 5,
    parameter int unsigned REFRESH_INTERVAL = 405
) (
    input  logic           clk,
    input  logic           resetn,
    vram_arbiter_if.slave  bus
);

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(SLOT_CYCLES);
    localparam int unsigned REF_W  = $clog2(REFRESH_INTERVAL + 1);

    localparam logic [1:0] SIZE_8  = 2'b00;
    localparam logic [1:0] SIZE_16 = 2'b01;
    localparam logic [1:0] SIZE_32 = 2'b10;

    // Reject configurations the slot sequencing cannot honour
    if (SLOT_CYCLES < 5 || FREQ == 0) begin : g_bad_params
        $error("vram_arbiter: SLOT_CYCLES must be >= 5 and FREQ nonzero");
    end

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

    typedef enum logic [1:0] {
        OWN_REND,
        OWN_CMD,
        OWN_CPU,
        OWN_REF
    } owner_e;

    state_e              state;
    owner_e              owner;
    logic                slot_rd;
    logic [CNT_W-1:0]    cnt;
    logic                cmd_pri;
    logic [REF_W-1:0]    ref_cnt;
    logic                ref_pending;

    logic                grant_ref;
    logic                grant_rend;
    logic                grant_cmd;
    logic                grant_cpu;
    logic [1:0]          cmd_wr_size;
    logic [DATA_W-1:0]   cmd_wr_data;

    // Fixed priority: pending refresh, renderer, then cmd/cpu round-robin
    always_comb begin
        grant_ref  = 1'b0;
        grant_rend = 1'b0;
        grant_cmd  = 1'b0;
        grant_cpu  = 1'b0;
        if (ref_pending) begin
            grant_ref = 1'b1;
        end else if (bus.rend_req) begin
            grant_rend = 1'b1;
        end else if (bus.cmd_req && (cmd_pri || !bus.cpu_req)) begin
            grant_cmd = 1'b1;
        end else if (bus.cpu_req) begin
            grant_cpu = 1'b1;
        end
    end

    // Command-engine write width and lane replication
    always_comb begin
        cmd_wr_size = SIZE_32;
        cmd_wr_data = bus.cmd_din;
        case (bus.cmd_size)
            SIZE_8: begin
                cmd_wr_size = SIZE_8;
                cmd_wr_data = {4{bus.cmd_din[7:0]}};
            end
            SIZE_16: begin
                cmd_wr_size = SIZE_16;
                cmd_wr_data = {2{bus.cmd_din[15:0]}};
            end
            default: begin
                cmd_wr_size = SIZE_32;
                cmd_wr_data = bus.cmd_din;
            end
        endcase
    end

    // Refresh timer: runs once the SDRAM is up; backlog is flagged sticky
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ref_cnt             <= REF_W'(REFRESH_INTERVAL);
            ref_pending         <= 1'b0;
            bus.refresh_overrun <= 1'b0;
        end else if (state != S_INIT) begin
            if (ref_cnt == '0) begin
                ref_cnt     <= REF_W'(REFRESH_INTERVAL);
                ref_pending <= 1'b1;
                if (ref_pending) begin
                    bus.refresh_overrun <= 1'b1;
                end
            end else begin
                ref_cnt <= ref_cnt - REF_W'(1);
                if (state == S_ISSUE && owner == OWN_REF) begin
                    ref_pending <= 1'b0;
                end
            end
        end
    end

    // Slot sequencer: grant in IDLE, strobe in ISSUE, hold through WAIT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state               <= S_INIT;
            owner               <= OWN_REND;
            slot_rd             <= 1'b0;
            cnt                 <= '0;
            cmd_pri             <= 1'b1;
            bus.rend_ack        <= 1'b0;
            bus.rend_rd_valid   <= 1'b0;
            bus.cmd_ack         <= 1'b0;
            bus.cmd_rd_valid    <= 1'b0;
            bus.cpu_ack         <= 1'b0;
            bus.cpu_rd_valid    <= 1'b0;
            bus.mc_read         <= 1'b0;
            bus.mc_write        <= 1'b0;
            bus.mc_refresh      <= 1'b0;
            bus.mc_addr         <= '0;
            bus.mc_word_wr_size <= SIZE_16;
            bus.mc_din          <= '0;
        end else begin
            bus.rend_ack      <= 1'b0;
            bus.rend_rd_valid <= 1'b0;
            bus.cmd_ack       <= 1'b0;
            bus.cmd_rd_valid  <= 1'b0;
            bus.cpu_ack       <= 1'b0;
            bus.cpu_rd_valid  <= 1'b0;
            bus.mc_read       <= 1'b0;
            bus.mc_write      <= 1'b0;
            bus.mc_refresh    <= 1'b0;

            case (state)
                S_INIT: begin
                    if (bus.mem_enabled) begin
                        state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (grant_ref) begin
                        owner               <= OWN_REF;
                        slot_rd             <= 1'b0;
                        bus.mc_word_wr_size <= SIZE_16;
                        state               <= S_ISSUE;
                    end else if (grant_rend) begin
                        owner               <= OWN_REND;
                        slot_rd             <= 1'b1;
                        bus.mc_addr         <= bus.rend_addr;
                        bus.mc_word_wr_size <= SIZE_16;
                        bus.rend_ack        <= 1'b1;
                        state               <= S_ISSUE;
                    end else if (grant_cmd) begin
                        owner               <= OWN_CMD;
                        slot_rd             <= !bus.cmd_wr;
                        bus.mc_addr         <= bus.cmd_addr;
                        bus.mc_word_wr_size <= bus.cmd_wr ? cmd_wr_size : SIZE_16;
                        bus.mc_din          <= cmd_wr_data;
                        bus.cmd_ack         <= 1'b1;
                        cmd_pri             <= 1'b0;
                        state               <= S_ISSUE;
                    end else if (grant_cpu) begin
                        owner               <= OWN_CPU;
                        slot_rd             <= !bus.cpu_wr;
                        bus.mc_addr         <= bus.cpu_addr;
                        bus.mc_word_wr_size <= bus.cpu_wr ? SIZE_8 : SIZE_16;
                        bus.mc_din          <= {4{bus.cpu_din}};
                        bus.cpu_ack         <= 1'b1;
                        cmd_pri             <= 1'b1;
                        state               <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (owner == OWN_REF) begin
                        bus.mc_refresh <= 1'b1;
                    end else if (slot_rd) begin
                        bus.mc_read <= 1'b1;
                    end else begin
                        bus.mc_write <= 1'b1;
                    end
                    cnt   <= CNT_W'(SLOT_CYCLES - 2);
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        if (slot_rd) begin
                            case (owner)
                                OWN_REND: bus.rend_rd_valid <= 1'b1;
                                OWN_CMD:  bus.cmd_rd_valid  <= 1'b1;
                                OWN_CPU:  bus.cpu_rd_valid  <= 1'b1;
                                default:  ;
                            endcase
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed requests push expected events,
// a negedge monitor pops and compares whatever the arbiter presents.
module tb_vram_arbiter;

    localparam int unsigned SLOT = 5;
    localparam int unsigned RI   = 405;
    localparam int unsigned RI2  = 4;

    typedef enum int {
        EV_ACK_REND, EV_ACK_CMD, EV_ACK_CPU,
        EV_READ, EV_WRITE,
        EV_RDV_REND, EV_RDV_CMD, EV_RDV_CPU
    } ev_kind_e;

    typedef struct {
        ev_kind_e    kind;
        logic [22:0] addr;
        logic [1:0]  size;
        logic [31:0] din;
    } ev_t;

    logic clk = 1'b0;
    logic resetn;
    logic resetn2;

    always #5 clk = ~clk;

    vram_arbiter_if bus1();
    vram_arbiter_if bus2();

    vram_arbiter #(.FREQ(54_000_000), .SLOT_CYCLES(SLOT), .REFRESH_INTERVAL(RI)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1.slave)
    );

    vram_arbiter #(.FREQ(54_000_000), .SLOT_CYCLES(SLOT), .REFRESH_INTERVAL(RI2)) dut2 (
        .clk    (clk),
        .resetn (resetn2),
        .bus    (bus2.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_events = 0;
    ev_t         exp_q[$];

    bit          stream_mode = 1'b0;
    logic [22:0] stream_addr = '0;
    int          last_ack_cyc = 0;
    int          last_strobe_cyc = 0;
    int          last_ref_cyc = -1;
    int          ref_count = 0;
    int          hold_left = 0;
    logic [22:0] slot_addr = '0;
    logic [31:0] slot_din  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void push(input ev_kind_e k, input logic [22:0] a,
                                 input logic [1:0] s, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.size = s;
        e.din  = d;
        exp_q.push_back(e);
    endfunction

    // Compare one observed event against the scoreboard head
    task automatic got_event(input ev_kind_e k);
        ev_t e;
        n_events++;
        if (stream_mode) begin
            if (k == EV_READ) check("stream_read_addr", 32'(bus1.mc_addr), 32'(stream_addr));
        end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got %s, expected none (cycle %0d)", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            if (k == EV_READ || k == EV_WRITE) begin
                check("mc_addr", 32'(bus1.mc_addr), 32'(e.addr));
                check("mc_size", 32'(bus1.mc_word_wr_size), 32'(e.size));
            end
            if (k == EV_WRITE) check("mc_din", bus1.mc_din, e.din);
        end
    endtask

    task automatic start_hold();
        slot_addr = bus1.mc_addr;
        slot_din  = bus1.mc_din;
        hold_left = SLOT - 1;
    endtask

    // Monitor on the falling edge, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (hold_left > 0) begin
                check("addr_hold", 32'(bus1.mc_addr), 32'(slot_addr));
                check("din_hold", bus1.mc_din, slot_din);
                check("strobe_single", 32'({bus1.mc_read, bus1.mc_write, bus1.mc_refresh}), 32'd0);
                hold_left--;
            end
            if (bus1.mc_refresh) begin
                n_events++;
                ref_count++;
                if (last_ref_cyc >= 0)
                    check("refresh_gap_in_window",
                          32'((cyc - last_ref_cyc >= int'(RI) - int'(SLOT) - 1) &&
                              (cyc - last_ref_cyc <= int'(RI) + int'(SLOT) + 2)), 32'd1);
                last_ref_cyc = cyc;
                start_hold();
            end
            if (bus1.rend_ack) begin got_event(EV_ACK_REND); last_ack_cyc = cyc; end
            if (bus1.cmd_ack)  begin got_event(EV_ACK_CMD);  last_ack_cyc = cyc; end
            if (bus1.cpu_ack)  begin got_event(EV_ACK_CPU);  last_ack_cyc = cyc; end
            if (bus1.mc_read || bus1.mc_write) begin
                check("ack_to_strobe", 32'(cyc - last_ack_cyc), 32'd1);
                got_event(bus1.mc_read ? EV_READ : EV_WRITE);
                last_strobe_cyc = cyc;
                start_hold();
            end
            if (bus1.rend_rd_valid || bus1.cmd_rd_valid || bus1.cpu_rd_valid) begin
                check("strobe_to_rd_valid", 32'(cyc - last_strobe_cyc), 32'(SLOT - 1));
                if (bus1.rend_rd_valid) got_event(EV_RDV_REND);
                if (bus1.cmd_rd_valid)  got_event(EV_RDV_CMD);
                if (bus1.cpu_rd_valid)  got_event(EV_RDV_CPU);
            end
        end
    end

    // Wait (bounded) for any grant on the main arbiter
    task automatic wait_ack(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus1.rend_ack || bus1.cmd_ack || bus1.cpu_ack) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: no grant within 300 cycles", name);
    endtask

    task automatic idle_inputs();
        bus1.rend_req = 0; bus1.rend_addr = '0;
        bus1.cmd_req = 0; bus1.cmd_wr = 0; bus1.cmd_size = 2'b00; bus1.cmd_addr = '0; bus1.cmd_din = '0;
        bus1.cpu_req = 0; bus1.cpu_wr = 0; bus1.cpu_addr = '0; bus1.cpu_din = '0;
        bus2.rend_req = 0; bus2.rend_addr = '0;
        bus2.cmd_req = 0; bus2.cmd_wr = 0; bus2.cmd_size = 2'b00; bus2.cmd_addr = '0; bus2.cmd_din = '0;
        bus2.cpu_req = 0; bus2.cpu_wr = 0; bus2.cpu_addr = '0; bus2.cpu_din = '0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ref_start;
        int waited;
        resetn  = 1'b0;
        resetn2 = 1'b0;
        bus1.mem_enabled = 1'b0;
        bus2.mem_enabled = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);

        // Reset values
        check("reset_pulses", 32'({bus1.rend_ack, bus1.rend_rd_valid, bus1.cmd_ack, bus1.cmd_rd_valid,
                                   bus1.cpu_ack, bus1.cpu_rd_valid, bus1.mc_read, bus1.mc_write,
                                   bus1.mc_refresh, bus1.refresh_overrun}), 32'd0);
        check("reset_addr", 32'(bus1.mc_addr), 32'd0);
        check("reset_din", bus1.mc_din, 32'd0);
        check("reset_size", 32'(bus1.mc_word_wr_size), 32'd1);
        resetn = 1'b1;

        // Held in INIT with everyone requesting: nothing may happen
        bus1.rend_req = 1; bus1.rend_addr = 23'h000010;
        bus1.cmd_req = 1; bus1.cmd_wr = 0; bus1.cmd_addr = 23'h000200;
        bus1.cpu_req = 1; bus1.cpu_wr = 1; bus1.cpu_addr = 23'h000301; bus1.cpu_din = 8'h3C;
        repeat (100) @(negedge clk);
        check("init_no_activity", 32'(n_events), 32'd0);

        push(EV_ACK_REND, '0, '0, '0);
        push(EV_READ, 23'h000010, 2'b01, '0);
        push(EV_RDV_REND, '0, '0, '0);
        push(EV_ACK_CMD, '0, '0, '0);
        push(EV_READ, 23'h000200, 2'b01, '0);
        push(EV_RDV_CMD, '0, '0, '0);
        push(EV_ACK_CPU, '0, '0, '0);
        push(EV_WRITE, 23'h000301, 2'b00, 32'h3C3C3C3C);
        bus1.mem_enabled = 1'b1;
        wait_ack("first_grant");  bus1.rend_req = 0;
        wait_ack("second_grant"); bus1.cmd_req = 0;
        wait_ack("third_grant");  bus1.cpu_req = 0;

        // cmd and cpu both streaming: strict alternation starting with cmd
        bus1.cmd_wr = 1; bus1.cmd_size = 2'b10; bus1.cmd_addr = 23'h000400; bus1.cmd_din = 32'h12345678;
        bus1.cpu_wr = 0; bus1.cpu_addr = 23'h000005;
        for (int i = 0; i < 2; i++) begin
            push(EV_ACK_CMD, '0, '0, '0);
            push(EV_WRITE, 23'h000400, 2'b10, 32'h12345678);
            push(EV_ACK_CPU, '0, '0, '0);
            push(EV_READ, 23'h000005, 2'b01, '0);
            push(EV_RDV_CPU, '0, '0, '0);
        end
        bus1.cmd_req = 1; bus1.cpu_req = 1;
        for (int i = 0; i < 4; i++) wait_ack("alternation_grant");
        bus1.cmd_req = 0; bus1.cpu_req = 0;

        // Byte write replicated over all lanes
        push(EV_ACK_CMD, '0, '0, '0);
        push(EV_WRITE, 23'h000003, 2'b00, 32'hA5A5A5A5);
        bus1.cmd_wr = 1; bus1.cmd_size = 2'b00; bus1.cmd_addr = 23'h000003; bus1.cmd_din = 32'h000000A5;
        bus1.cmd_req = 1;
        wait_ack("cmd_byte_write"); bus1.cmd_req = 0;

        // Halfword write replicated twice
        push(EV_ACK_CMD, '0, '0, '0);
        push(EV_WRITE, 23'h000010, 2'b01, 32'hBEEFBEEF);
        bus1.cmd_size = 2'b01; bus1.cmd_addr = 23'h000010; bus1.cmd_din = 32'hDEADBEEF;
        bus1.cmd_req = 1;
        wait_ack("cmd_half_write"); bus1.cmd_req = 0;

        // Renderer beats cmd when both arrive together; top address
        push(EV_ACK_REND, '0, '0, '0);
        push(EV_READ, 23'h7FFFFF, 2'b01, '0);
        push(EV_RDV_REND, '0, '0, '0);
        push(EV_ACK_CMD, '0, '0, '0);
        push(EV_READ, 23'h000020, 2'b01, '0);
        push(EV_RDV_CMD, '0, '0, '0);
        bus1.rend_addr = 23'h7FFFFF;
        bus1.cmd_wr = 0; bus1.cmd_addr = 23'h000020;
        bus1.rend_req = 1; bus1.cmd_req = 1;
        wait_ack("prio_first");  bus1.rend_req = 0;
        wait_ack("prio_second"); bus1.cmd_req = 0;

        // CPU byte write of all-ones
        push(EV_ACK_CPU, '0, '0, '0);
        push(EV_WRITE, 23'h123456, 2'b00, 32'hFFFFFFFF);
        bus1.cpu_wr = 1; bus1.cpu_addr = 23'h123456; bus1.cpu_din = 8'hFF;
        bus1.cpu_req = 1;
        wait_ack("cpu_write"); bus1.cpu_req = 0;

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Continuous renderer load: refresh must still get through
        stream_addr   = 23'h0ABCDE;
        bus1.rend_addr = stream_addr;
        stream_mode   = 1'b1;
        ref_start     = ref_count;
        bus1.rend_req = 1;
        repeat (1400) @(negedge clk);
        wait_ack("stream_last");
        bus1.rend_req = 0;
        repeat (12) @(negedge clk);
        stream_mode = 1'b0;
        check("refreshes_under_load", 32'(ref_count - ref_start >= 3), 32'd1);
        check("no_overrun_main", 32'(bus1.refresh_overrun), 32'd0);

        // Short refresh interval: backlog builds and the sticky flag sets
        bus2.mem_enabled = 1'b1;
        bus2.rend_addr   = 23'h000055;
        bus2.rend_req    = 1;
        resetn2          = 1'b1;
        repeat (60) @(negedge clk);
        check("overrun_set", 32'(bus2.refresh_overrun), 32'd1);

        waited = 0;
        while (!(bus2.mc_refresh || bus2.mc_read) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("dut2_strobe_seen", 32'(bus2.mc_refresh || bus2.mc_read), 32'd1);
        @(negedge clk);
        #2 resetn2 = 1'b0;
        #1;
        check("async_reset_pulses", 32'({bus2.rend_ack, bus2.rend_rd_valid, bus2.cmd_ack, bus2.cmd_rd_valid,
                                         bus2.cpu_ack, bus2.cpu_rd_valid, bus2.mc_read, bus2.mc_write,
                                         bus2.mc_refresh, bus2.refresh_overrun}), 32'd0);
        check("async_reset_addr", 32'(bus2.mc_addr), 32'd0);
        check("async_reset_din", bus2.mc_din, 32'd0);
        check("async_reset_size", 32'(bus2.mc_word_wr_size), 32'd1);
        repeat (3) @(negedge clk);
        check("reset_held_quiet", 32'({bus2.rend_ack, bus2.mc_read, bus2.mc_refresh, bus2.rend_rd_valid}), 32'd0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_no_overrun_main", 32'(bus1.refresh_overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
